// File: rtl/aes_pkg.sv
// aes_pkg: shared types, block geometry, FSM states and the counter-increment helper for the AES CTR sequencer.
package aes_pkg;
   typedef logic [127:0] block_t;
   typedef logic [31:0]  word_t;
   localparam int WORDS_PER_BLK = 4;
   typedef enum logic [2:0] {IDLE, FILL, LOAD, WAIT, OUT} ctr_state_e;
   // Increment only the low ctr_w bits modulo 2^ctr_w; the carry never reaches the upper bits.
   function automatic block_t ctr_inc(block_t ctr, int ctr_w);
      block_t mask;
      mask = (ctr_w >= 128) ? '1 : ((block_t'(1) << ctr_w) - block_t'(1));
      return (ctr & ~mask) | ((ctr + block_t'(1)) & mask);
   endfunction
endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: packs 32-bit words into a 128-bit block, tracks word count and last flag, and builds the valid-word mask.
// Ports: clk, rst (async active-low); clr clears buffer and index; wr_en/wr_data/wr_last write one word;
//        blk_done flags the word that closes a block; blk_data is the buffer; blk_mask keeps words below blk_wcnt;
//        blk_wcnt/blk_last are the count and last flag captured when the block closed.
module aes_word_packer
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       wr_en,
   input  word_t      wr_data,
   input  logic       wr_last,
   output logic       blk_done,
   output block_t     blk_data,
   output block_t     blk_mask,
   output logic [2:0] blk_wcnt,
   output logic       blk_last
);
   block_t     buf_q, buf_d;
   logic [1:0] idx_q, idx_d;
   logic [2:0] wcnt_q, wcnt_d;
   logic       last_q, last_d;
   always_comb begin
      buf_d    = buf_q;
      idx_d    = idx_q;
      wcnt_d   = wcnt_q;
      last_d   = last_q;
      blk_done = wr_en && (idx_q == 2'(WORDS_PER_BLK - 1) || wr_last);
      if (clr) begin
         buf_d = '0;
         idx_d = '0;
      end else if (wr_en) begin
         // Word idx lands at bit offset (3-idx)*32, i.e. {~idx, 5'b0}.
         buf_d[{~idx_q, 5'd0} +: 32] = wr_data;
         idx_d = blk_done ? 2'd0 : idx_q + 2'd1;
         wcnt_d = blk_done ? {1'b0, idx_q} + 3'd1 : wcnt_q;
         last_d = blk_done ? wr_last : last_q;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q  <= '0;
         idx_q  <= '0;
         wcnt_q <= '0;
         last_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         idx_q  <= idx_d;
         wcnt_q <= wcnt_d;
         last_q <= last_d;
      end
   end
   // Top wcnt words are valid: ones shifted out of the low (4-wcnt) words.
   assign blk_mask = ~({128{1'b1}} >> {wcnt_q, 5'd0});
   assign blk_data = buf_q;
   assign blk_wcnt = wcnt_q;
   assign blk_last = last_q;
endmodule

// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: drives an AES-128 core in CTR mode, XORing keystream blocks with packed 32-bit input words.
// Ports: clk, rst (async active-low); cfg_start/cfg_iv/cfg_key start a message; in_* is the 32-bit word stream;
//        out_* is the 128-bit result stream with word count and last flag; core_* talks to aes_cipher_top; busy = not IDLE.
module aes_ctr_sequencer
   import aes_pkg::*;
#(
   parameter int CTR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cfg_start,
   input  logic [127:0] cfg_iv,
   input  logic [127:0] cfg_key,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [2:0]   out_wcnt,
   output logic         out_last,
   output logic         core_ld,
   output logic [127:0] core_key,
   output logic [127:0] core_text_in,
   input  logic [127:0] core_text_out,
   input  logic         core_done,
   output logic         busy
);
   ctr_state_e state_q, state_d;
   block_t     ctr_q, ctr_d, key_q, key_d, text_q, text_d, odata_q, odata_d;
   logic [2:0] owcnt_q, owcnt_d;
   logic       olast_q, olast_d;
   logic       clr, blk_done, blk_last;
   block_t     blk_data, blk_mask;
   logic [2:0] blk_wcnt;
   aes_word_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .wr_en    (in_valid && in_ready),
      .wr_data  (in_data),
      .wr_last  (in_last),
      .blk_done (blk_done),
      .blk_data (blk_data),
      .blk_mask (blk_mask),
      .blk_wcnt (blk_wcnt),
      .blk_last (blk_last)
   );
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      key_d   = key_q;
      text_d  = text_q;
      odata_d = odata_q;
      owcnt_d = owcnt_q;
      olast_d = olast_q;
      clr     = 1'b0;
      case (state_q)
         IDLE: if (cfg_start) begin
            ctr_d   = cfg_iv;
            key_d   = cfg_key;
            clr     = 1'b1;
            state_d = FILL;
         end
         FILL: if (blk_done) begin
            // Capture the counter here so core_text_in is stable from LOAD until the next LOAD.
            text_d  = ctr_q;
            state_d = LOAD;
         end
         LOAD: state_d = WAIT;
         WAIT: if (core_done) begin
            odata_d = (core_text_out ^ blk_data) & blk_mask;
            owcnt_d = blk_wcnt;
            olast_d = blk_last;
            ctr_d   = ctr_inc(ctr_q, CTR_W);
            state_d = OUT;
         end
         OUT: if (out_ready) begin
            clr     = 1'b1;
            state_d = olast_q ? IDLE : FILL;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         key_q   <= '0;
         text_q  <= '0;
         odata_q <= '0;
         owcnt_q <= '0;
         olast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         key_q   <= key_d;
         text_q  <= text_d;
         odata_q <= odata_d;
         owcnt_q <= owcnt_d;
         olast_q <= olast_d;
      end
   end
   assign in_ready     = state_q == FILL;
   assign out_valid    = state_q == OUT;
   assign core_ld      = state_q == LOAD;
   assign busy         = state_q != IDLE;
   assign out_data     = odata_q;
   assign out_wcnt     = owcnt_q;
   assign out_last     = out_valid && olast_q;
   assign core_key     = key_q;
   assign core_text_in = text_q;
endmodule
